// File: rtl/search_mem_loader.sv
// Double-buffered block-match memory loader.
// Packs a byte stream into the write bank while the consumer reads the other.
module search_mem_loader #(
  parameter int cur_addr_max = 5,
  parameter int ref_addr_max = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic [7:0]              pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    done,
  output logic                    go,
  input  logic [cur_addr_max-1:0] addrCur,
  input  logic [ref_addr_max-1:0] addrRef,
  output logic [63:0]             rdatCur,
  output logic [63:0]             rdatRef,
  output logic                    bank_sel,
  output logic                    busy
);

  localparam int CUR_WORDS = 1 << cur_addr_max;
  localparam int REF_WORDS = 1 << ref_addr_max;
  localparam int WCW =
    (ref_addr_max > cur_addr_max) ? ref_addr_max : cur_addr_max;
  localparam logic [WCW-1:0] CUR_LAST = WCW'(CUR_WORDS - 1);
  localparam logic [WCW-1:0] REF_LAST = WCW'(REF_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_CUR,
    LOAD_REF,
    READY
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       byte_q, byte_d;
  logic [WCW-1:0]   word_q, word_d;
  logic [55:0]      pack_q, pack_d;
  logic             bank_q, bank_d;
  logic             busy_q, busy_d;
  logic             go_q, go_d;

  logic             accept;
  logic             cur_we;
  logic             ref_we;
  logic [63:0]      wdata;
  logic             wbank;

  logic [63:0] cur_mem_q [2][CUR_WORDS];
  logic [63:0] ref_mem_q [2][REF_WORDS];

  assign pix_ready = (state_q == LOAD_CUR) || (state_q == LOAD_REF);
  assign accept    = pix_valid && pix_ready;
  assign wdata     = {pix_in, pack_q};
  assign wbank     = ~bank_q;

  assign go       = go_q;
  assign busy     = busy_q;
  assign bank_sel = bank_q;

  assign rdatCur = cur_mem_q[bank_q][addrCur];
  assign rdatRef = ref_mem_q[bank_q][addrRef];

  // Control and handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      word_q  <= '0;
      pack_q  <= '0;
      bank_q  <= 1'b0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      pack_q  <= pack_d;
      bank_q  <= bank_d;
      busy_q  <= busy_d;
      go_q    <= go_d;
    end
  end

  // Next-state, byte packing, word writes and the bank swap.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    word_d  = word_q;
    pack_d  = pack_q;
    bank_d  = bank_q;
    busy_d  = busy_q && !done;
    go_d    = 1'b0;
    cur_we  = 1'b0;
    ref_we  = 1'b0;

    if (accept) begin
      byte_d = byte_q + 3'd1;
      if (byte_q != 3'd7) begin
        pack_d[{byte_q, 3'b000} +: 8] = pix_in;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD_CUR;
          byte_d  = '0;
          word_d  = '0;
        end
      end
      LOAD_CUR: begin
        if (accept && byte_q == 3'd7) begin
          cur_we = 1'b1;
          if (word_q == CUR_LAST) begin
            state_d = LOAD_REF;
            word_d  = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      LOAD_REF: begin
        if (accept && byte_q == 3'd7) begin
          ref_we = 1'b1;
          if (word_q == REF_LAST) begin
            state_d = READY;
            word_d  = '0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      READY: begin
        if (!busy_d) begin
          bank_d  = ~bank_q;
          go_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two banks of storage; only the bank hidden from readers is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < CUR_WORDS; i++) begin
          cur_mem_q[b][i] <= '0;
        end
        for (int i = 0; i < REF_WORDS; i++) begin
          ref_mem_q[b][i] <= '0;
        end
      end
    end else begin
      if (cur_we) begin
        cur_mem_q[wbank][word_q[cur_addr_max-1:0]] <= wdata;
      end
      if (ref_we) begin
        ref_mem_q[wbank][word_q[ref_addr_max-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: doc/search_mem_loader.md
SEARCH_MEM_LOADER -- requirements
Module: search_mem_loader

Interface
REQ-001 The module SHALL have parameter cur_addr_max, default 5, giving the current-block word address width (32 words = 16x16 pixels).
REQ-002 The module SHALL have parameter ref_addr_max, default 8, giving the reference-window word address width (256 words).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_start  input  1  one-cycle pulse that begins loading one frame pair.
REQ-006 pix_in  input  8  incoming pixel byte.
REQ-007 pix_valid  input  1  pix_in holds a valid byte.
REQ-008 pix_ready  output  1  the loader accepts a byte this cycle.
REQ-009 done  input  1  one-cycle pulse: the consumer has finished the read bank.
REQ-010 go  output  1  one-cycle pulse: the read bank holds a new frame pair.
REQ-011 addrCur  input  cur_addr_max  current-block read word address.
REQ-012 addrRef  input  ref_addr_max  reference-window read word address.
REQ-013 rdatCur  output  64  current-block read data.
REQ-014 rdatRef  output  64  reference read data.
REQ-015 bank_sel  output  1  index of the bank currently exposed for reads.
REQ-016 busy  output  1  the consumer owns the read bank (set by go, cleared by done).

Function
REQ-017 Storage SHALL be two banks, each with a 2^cur_addr_max x 64 cur array and a 2^ref_addr_max x 64 ref array; writes SHALL go to bank !bank_sel, and reads SHALL come from bank bank_sel.
REQ-018 rdatCur and rdatRef SHALL be combinational (0-cycle) reads of the read bank at addrCur and addrRef.
REQ-019 FSM states SHALL be IDLE, LOAD_CUR, LOAD_REF, READY.
REQ-020 IDLE SHALL go to LOAD_CUR on load_start and SHALL clear the byte and word counters; load_start SHALL be ignored in any other state.
REQ-021 pix_ready SHALL be 1 exactly in LOAD_CUR and LOAD_REF; a byte SHALL be accepted when pix_valid && pix_ready.
REQ-022 Accepted bytes SHALL be packed little-endian: byte k of a word (k = 0..7, 3-bit counter) goes to bits [8k+7:8k].
REQ-023 On the 8th byte, the completed word SHALL be written at the word counter, and the word counter SHALL increment.
REQ-024 LOAD_CUR SHALL transition to LOAD_REF after word 2^cur_addr_max-1 is written; the word counter SHALL reset to 0.
REQ-025 LOAD_REF SHALL transition to READY after word 2^ref_addr_max-1 is written.
REQ-026 In READY, when busy_next = busy && !done is 0, the block SHALL toggle bank_sel, pulse go for one cycle, set busy, and return to IDLE, all on the same edge.
REQ-027 done and the READY swap in the same cycle SHALL swap on that edge, with busy remaining 1.
REQ-028 done while busy = 0 SHALL be ignored.
REQ-029 pix_valid outside the LOAD states SHALL be ignored, with no write and no counter change.
REQ-030 A new load SHALL be permitted while busy = 1, since it writes only the other bank; the read bank SHALL never be written.
REQ-031 A partial word (fewer than 8 bytes) SHALL never be written.

Reset
REQ-032 On reset low, the block SHALL immediately enter IDLE, with bank_sel = 0, busy = 0, go = 0, pix_ready = 0, all counters = 0, and all memory words = 0, so rdatCur = rdatRef = 0.
REQ-033 Reset asserted mid-load SHALL discard the partial load; after release, the block SHALL wait in IDLE for load_start.

Verification
REQ-034 Reset, then read addrCur = 3, addrRef = 200 -> rdatCur = rdatRef = 0, bank_sel = 0, pix_ready = 0.
REQ-035 load_start, then bytes 0x00..0xFF (cur) followed by 2048 bytes of value (i mod 256) (ref), pix_valid held 1 -> go pulses once; bank_sel = 1; rdatCur at addr 0 = 0x0706050403020100; rdatRef at addr 1 = 0x0F0E0D0C0B0A0908.
REQ-036 Second full load while busy = 1 -> READY is held, go = 0 and bank_sel is unchanged until done pulses; on the done cycle, swap occurs with bank_sel = 0, go = 1 and busy = 1.
REQ-037 pix_valid toggling 1/0 every cycle during load -> identical memory contents to REQ-035; pix_ready stays 1; the load takes 2x the cycles.
REQ-038 Reset low after 100 ref bytes, release, then a full load -> data equals the new stream only; go pulses once.
REQ-039 load_start pulsed during LOAD_REF and pix_valid in IDLE -> no state, counter or memory change.
